// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin arbiter sharing the byte-wide USB-UART transmit port among several clients.
// A grant stays locked to one client until it sends its last byte or hits MAX_BURST.
// While the host is absent, granted bytes can be drained and counted instead of stalling.
module usb_uart_tx_arbiter #(
   parameter int unsigned NUM_CLIENTS      = 4,
   parameter int unsigned MAX_BURST        = 64,
   parameter bit          DROP_WHEN_ABSENT = 1'b1
) (
   input  logic                     clk_48mhz,
   input  logic                     reset,
   input  logic [NUM_CLIENTS-1:0]   req_valid,
   input  logic [8*NUM_CLIENTS-1:0] req_data,
   input  logic [NUM_CLIENTS-1:0]   req_last,
   output logic [NUM_CLIENTS-1:0]   req_ready,
   input  logic                     host_present,
   output logic                     uart_we,
   output logic [7:0]               uart_di,
   input  logic                     uart_wait,
   output logic [NUM_CLIENTS-1:0]   grant,
   output logic                     busy,
   output logic [15:0]              drop_count
);

   localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDrop} state_e;

   state_e                 state_q, state_d;
   logic [IdxW-1:0]        owner_q, owner_d;
   logic [IdxW-1:0]        last_q, last_d;
   logic [7:0]             burst_q, burst_d;
   logic [15:0]            drop_q, drop_d;

   logic [IdxW-1:0]        cand;
   logic [IdxW-1:0]        sel_idx;
   logic                   sel_found;
   logic                   own_valid, own_last;
   logic [7:0]             own_data;
   logic [NUM_CLIENTS-1:0] owner_oh;
   logic                   beat;

   // Round-robin search: first valid client after the previous owner, wrapping.
   always_comb begin
      cand      = '0;
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int unsigned off = 1; off <= NUM_CLIENTS; off++) begin
         cand = IdxW'((32'(last_q) + off) % NUM_CLIENTS);
         if (!sel_found && req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Route the owner's handshake and data; other clients never reach the bridge.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      owner_oh  = '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         if (owner_q == IdxW'(i)) begin
            own_valid   = req_valid[i];
            own_last    = req_last[i];
            own_data    = req_data[8*i +: 8];
            owner_oh[i] = 1'b1;
         end
      end
   end

   // Next-state, handshake and bridge outputs.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      burst_d   = burst_q;
      drop_d    = drop_q;
      req_ready = '0;
      uart_we   = 1'b0;
      uart_di   = '0;
      beat      = 1'b0;

      unique case (state_q)
         StIdle: begin
            // With backpressure configured and no host, hold off granting entirely.
            if (sel_found && (host_present || DROP_WHEN_ABSENT)) begin
               owner_d = sel_idx;
               last_d  = sel_idx;
               burst_d = '0;
               state_d = host_present ? StBusy : StDrop;
            end
         end
         StBusy: begin
            uart_we   = own_valid;
            uart_di   = own_data;
            req_ready = owner_oh & {NUM_CLIENTS{~uart_wait}};
            beat      = own_valid & ~uart_wait;
            if (!host_present && DROP_WHEN_ABSENT) state_d = StDrop;
         end
         StDrop: begin
            uart_di   = own_data;
            req_ready = owner_oh;
            beat      = own_valid;
            if (beat && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
         end
         default: state_d = StIdle;
      endcase

      // Packet end or burst cap releases the grant; this wins over a host-loss move to DROP.
      if (beat) begin
         burst_d = burst_q + 8'd1;
         if (own_last || ({1'b0, burst_q} + 9'd1 == 9'(MAX_BURST))) state_d = StIdle;
      end
   end

   // State registers with synchronous reset; pointer starts so client 0 wins first.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q <= StIdle;
         owner_q <= '0;
         last_q  <= IdxW'(NUM_CLIENTS - 1);
         burst_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         drop_q  <= drop_d;
      end
   end

   assign grant      = (state_q != StIdle) ? owner_oh : '0;
   assign busy       = (state_q != StIdle);
   assign drop_count = drop_q;

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Directed bench for usb_uart_tx_arbiter: a vector table for single-client and backpressure
// traffic, plus hand-written sequences for round robin, burst cap, host loss and reset.
module tb_usb_uart_tx_arbiter;

   logic        clk_48mhz = 1'b0;
   logic        reset     = 1'b1;
   logic [3:0]  req_valid = '0, req_last = '0, req_ready, grant;
   logic [31:0] req_data  = '0;
   logic        host_present = 1'b1, uart_wait = 1'b0, uart_we, busy;
   logic [7:0]  uart_di;
   logic [15:0] drop_count;

   // Second instance with a small burst cap for the fairness test.
   logic [3:0]  b_valid = '0, b_last = '0, b_ready, b_grant;
   logic [31:0] b_data  = '0;
   logic        b_we, b_busy;
   logic [7:0]  b_di;
   logic [15:0] b_drop;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] bridge_q[$];
   logic [7:0] b_bridge_q[$];

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  last;
      logic        wt;
      logic        host;
      logic [3:0]  e_grant;
      logic        e_we;
      logic [7:0]  e_di;
      logic [3:0]  e_ready;
      logic        e_busy;
   } vec_t;

   vec_t       vecs[16];
   logic [7:0] exp_seq1[9]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h20, 8'h21, 8'h22, 8'h23};
   logic [3:0] exp_rr[6]    = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
   logic [7:0] exp_rr_b[6]  = '{8'hA0, 8'hA2, 8'hA3, 8'hA0, 8'hA2, 8'hA3};
   logic [7:0] exp_burst[11] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h54, 8'h55, 8'h56,
                                 8'h57, 8'h58, 8'h59};
   logic [7:0] exp_host[3]  = '{8'h30, 8'h31, 8'h32};

   usb_uart_tx_arbiter #(.NUM_CLIENTS(4), .MAX_BURST(64), .DROP_WHEN_ABSENT(1'b1)) dut (
      .clk_48mhz    (clk_48mhz),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .host_present (host_present),
      .uart_we      (uart_we),
      .uart_di      (uart_di),
      .uart_wait    (uart_wait),
      .grant        (grant),
      .busy         (busy),
      .drop_count   (drop_count)
   );

   usb_uart_tx_arbiter #(.NUM_CLIENTS(4), .MAX_BURST(4), .DROP_WHEN_ABSENT(1'b1)) dut_b (
      .clk_48mhz    (clk_48mhz),
      .reset        (reset),
      .req_valid    (b_valid),
      .req_data     (b_data),
      .req_last     (b_last),
      .req_ready    (b_ready),
      .host_present (1'b1),
      .uart_we      (b_we),
      .uart_di      (b_di),
      .uart_wait    (1'b0),
      .grant        (b_grant),
      .busy         (b_busy),
      .drop_count   (b_drop)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   // Bridge-side capture of every transferred byte.
   always @(posedge clk_48mhz) if (!reset && uart_we && !uart_wait) bridge_q.push_back(uart_di);
   always @(posedge clk_48mhz) if (!reset && b_we) b_bridge_q.push_back(b_di);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk_48mhz);
      reset = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0; host_present = 1'b1; uart_wait = 1'b0;
      b_valid = '0; b_last = '0; b_data = '0;
      @(negedge clk_48mhz);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] gseq[$];
      logic [7:0] rr_bytes[$];
      logic       acc, acc1;
      int         idx;
      bit         c1_done;

      // Single client 1: five bytes, last on 0x14.
      vecs[0]  = '{4'b0010, 32'h0000_1000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
      vecs[1]  = '{4'b0010, 32'h0000_1000, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 8'h10, 4'b0010, 1'b1};
      vecs[2]  = '{4'b0010, 32'h0000_1100, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 8'h11, 4'b0010, 1'b1};
      vecs[3]  = '{4'b0010, 32'h0000_1200, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 8'h12, 4'b0010, 1'b1};
      vecs[4]  = '{4'b0010, 32'h0000_1300, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 8'h13, 4'b0010, 1'b1};
      vecs[5]  = '{4'b0010, 32'h0000_1400, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 8'h14, 4'b0010, 1'b1};
      vecs[6]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
      // Client 2 with three stalled cycles on byte 0x21.
      vecs[7]  = '{4'b0100, 32'h0020_0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
      vecs[8]  = '{4'b0100, 32'h0020_0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h20, 4'b0100, 1'b1};
      vecs[9]  = '{4'b0100, 32'h0021_0000, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h21, 4'b0000, 1'b1};
      vecs[10] = '{4'b0100, 32'h0021_0000, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h21, 4'b0000, 1'b1};
      vecs[11] = '{4'b0100, 32'h0021_0000, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h21, 4'b0000, 1'b1};
      vecs[12] = '{4'b0100, 32'h0021_0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h21, 4'b0100, 1'b1};
      vecs[13] = '{4'b0100, 32'h0022_0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h22, 4'b0100, 1'b1};
      vecs[14] = '{4'b0100, 32'h0023_0000, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h23, 4'b0100, 1'b1};
      vecs[15] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};

      // Reset state: all clients requesting while reset is held must not be granted.
      @(negedge clk_48mhz);
      req_valid = 4'b1111;
      @(negedge clk_48mhz);
      #1;
      chk("reset grant", 32'(grant), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset we", 32'(uart_we), 32'h0);
      chk("reset ready", 32'(req_ready), 32'h0);
      chk("reset drop_count", 32'(drop_count), 32'h0);
      @(negedge clk_48mhz);
      reset = 1'b0;
      req_valid = '0;

      bridge_q.delete();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_48mhz);
         req_valid    = vecs[i].valid;
         req_data     = vecs[i].data;
         req_last     = vecs[i].last;
         uart_wait    = vecs[i].wt;
         host_present = vecs[i].host;
         #1;
         chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].e_grant));
         chk($sformatf("vec%0d we", i), 32'(uart_we), 32'(vecs[i].e_we));
         chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
         chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         if (vecs[i].e_we) chk($sformatf("vec%0d di", i), 32'(uart_di), 32'(vecs[i].e_di));
      end
      @(negedge clk_48mhz);
      chk("table bridge count", 32'(bridge_q.size()), 32'd9);
      for (int i = 0; i < 9; i++)
         if (i < bridge_q.size()) chk($sformatf("table bridge byte%0d", i), 32'(bridge_q[i]),
                                      32'(exp_seq1[i]));

      // Round robin among clients 0, 2, 3 with single-byte packets.
      do_reset();
      bridge_q.delete();
      req_valid = 4'b1101;
      req_last  = 4'b1111;
      req_data  = 32'hA3A2_A1A0;
      for (int cyc = 0; cyc < 40 && gseq.size() < 6; cyc++) begin
         @(negedge clk_48mhz);
         #1;
         if (grant != 4'b0000) gseq.push_back(grant);
      end
      req_valid = '0;
      @(negedge clk_48mhz);
      for (int i = 0; i < 6 && i < bridge_q.size(); i++) rr_bytes.push_back(bridge_q[i]);
      chk("rr grant count", 32'(gseq.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < gseq.size()) chk($sformatf("rr grant%0d", i), 32'(gseq[i]), 32'(exp_rr[i]));
      for (int i = 0; i < 6; i++)
         if (i < rr_bytes.size()) chk($sformatf("rr byte%0d", i), 32'(rr_bytes[i]),
                                      32'(exp_rr_b[i]));

      // Burst cap of 4: client 0 streams 10 bytes, client 1 waits with one byte.
      do_reset();
      b_bridge_q.delete();
      idx = 0;
      c1_done = 1'b0;
      for (int cyc = 0; cyc < 100 && (idx < 10 || !c1_done); cyc++) begin
         @(negedge clk_48mhz);
         b_valid = {2'b00, !c1_done, idx < 10};
         b_data  = {16'h0000, 8'h60, 8'(8'h50 + idx)};
         b_last  = 4'b0010;
         #1;
         acc  = b_valid[0] & b_ready[0];
         acc1 = b_valid[1] & b_ready[1];
         @(posedge clk_48mhz);
         if (acc) idx++;
         if (acc1) c1_done = 1'b1;
      end
      @(negedge clk_48mhz);
      b_valid = '0;
      chk("burst byte count", 32'(b_bridge_q.size()), 32'd11);
      for (int i = 0; i < 11; i++)
         if (i < b_bridge_q.size()) chk($sformatf("burst byte%0d", i), 32'(b_bridge_q[i]),
                                        32'(exp_burst[i]));

      // Host loss: host falls while byte 2 is accepted; bytes 3..5 are drained.
      do_reset();
      bridge_q.delete();
      idx = 0;
      for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
         @(negedge clk_48mhz);
         req_valid    = {3'b000, idx < 6};
         req_data     = {24'h0, 8'(8'h30 + idx)};
         req_last     = {3'b000, idx == 5};
         host_present = (idx <= 1);
         #1;
         if (idx >= 3) begin
            chk($sformatf("drop%0d we", idx), 32'(uart_we), 32'h0);
            chk($sformatf("drop%0d ready", idx), 32'(req_ready), 32'h1);
         end
         acc = req_valid[0] & req_ready[0];
         @(posedge clk_48mhz);
         if (acc) idx++;
      end
      @(negedge clk_48mhz);
      req_valid = '0;
      req_last  = '0;
      #1;
      chk("host loss grant released", 32'(grant), 32'h0);
      chk("host loss drop_count", 32'(drop_count), 32'd3);
      chk("host loss bridge count", 32'(bridge_q.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < bridge_q.size()) chk($sformatf("host loss byte%0d", i), 32'(bridge_q[i]),
                                      32'(exp_host[i]));
      // Host back: next packet reaches the bridge again.
      host_present = 1'b1;
      bridge_q.delete();
      acc = 1'b0;
      for (int cyc = 0; cyc < 10 && !acc; cyc++) begin
         @(negedge clk_48mhz);
         req_valid = 4'b0010;
         req_data  = 32'h0000_4000;
         req_last  = 4'b0010;
         #1;
         acc = req_valid[1] & req_ready[1];
         @(posedge clk_48mhz);
      end
      @(negedge clk_48mhz);
      req_valid = '0;
      req_last  = '0;
      chk("host back bridge count", 32'(bridge_q.size()), 32'd1);
      if (bridge_q.size() > 0) chk("host back byte", 32'(bridge_q[0]), 32'h40);
      chk("host back drop_count held", 32'(drop_count), 32'd3);

      // Reset during byte 3 of a client 2 packet, with drop_count still nonzero.
      idx = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk_48mhz);
         req_valid = 4'b0100;
         req_data  = {8'h00, 8'(8'h70 + idx), 16'h0000};
         req_last  = '0;
         if (idx == 3) reset = 1'b1;
         #1;
         acc = req_valid[2] & req_ready[2];
         @(posedge clk_48mhz);
         if (reset) break;
         if (acc) idx++;
      end
      @(negedge clk_48mhz);
      reset     = 1'b0;
      req_valid = 4'b1001;
      req_data  = 32'hC300_00C0;
      req_last  = 4'b1001;
      #1;
      chk("mid reset grant", 32'(grant), 32'h0);
      chk("mid reset we", 32'(uart_we), 32'h0);
      chk("mid reset busy", 32'(busy), 32'h0);
      chk("mid reset drop_count", 32'(drop_count), 32'h0);
      @(negedge clk_48mhz);
      #1;
      chk("post reset first grant", 32'(grant), 32'b0001);
      req_valid = '0;
      @(negedge clk_48mhz);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
